led_pattern_ctrl: RTL and testbench

- Parametrised LED driver for the iCEstick LED bank; successor to the fixed all-on LED driver.
- Drives NUM_LEDS outputs from a loaded pattern in one of four modes: static, blink, chase (rotate), bounce.
- Global PWM brightness is applied on top of every mode.
- Sits between top-level control logic (buttons/UART command decoder) and the board LED pins.

---
 rtl/led_pattern_ctrl.sv | 144 ++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl
//   Drives a bank of NUM_LEDS board LEDs from a loaded pattern. There are four
//   modes: static, blink, chase (rotate) and bounce. A global PWM brightness
//   is applied on top of whichever mode is active.
//
// Ports
//   clk        system clock (12 MHz on the iCEstick)
//   rst        synchronous, active-high reset
//   load       one-cycle strobe; captures mode/pattern/duty and restarts the
//              step timer
//   mode       0=STATIC 1=BLINK 2=CHASE 3=BOUNCE (sampled on load)
//   pattern    initial LED pattern (sampled on load)
//   duty       PWM brightness, all ones = fully on (sampled on load)
//   leds       registered LED drive, bit 0 = D1
//   step_tick  registered one-cycle pulse on every pattern step
//
// Bounce direction state
//   state     | meaning
//   DIR_LEFT  | pattern moves toward the MSB, zero-filled
//   DIR_RIGHT | pattern moves toward bit 0, zero-filled
module led_pattern_ctrl #(
  parameter int NUM_LEDS = 5,
  parameter int PRESCALE = 3000000,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [1:0]          mode,
  input  logic [NUM_LEDS-1:0] pattern,
  input  logic [PWM_BITS-1:0] duty,
  output logic [NUM_LEDS-1:0] leds,
  output logic                step_tick
);

  localparam int PS_W = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  mode_e               mode_r,    mode_r_nxt;
  dir_e                dir,       dir_nxt;
  logic [NUM_LEDS-1:0] shreg,     shreg_nxt;
  logic [PWM_BITS-1:0] duty_r,    duty_r_nxt;
  logic [PS_W-1:0]     prescaler, prescaler_nxt;
  logic [PWM_BITS-1:0] pwm_cnt,   pwm_cnt_nxt;
  logic                blink_ph,  blink_ph_nxt;
  logic [NUM_LEDS-1:0] leds_nxt;
  logic                step_tick_nxt;
  logic [NUM_LEDS-1:0] vis;
  logic                pwm_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r    <= MODE_STATIC;
      dir       <= DIR_LEFT;
      shreg     <= '0;
      duty_r    <= '1;
      prescaler <= '0;
      pwm_cnt   <= '0;
      blink_ph  <= 1'b1;
      leds      <= '0;
      step_tick <= 1'b0;
    end else begin
      mode_r    <= mode_r_nxt;
      dir       <= dir_nxt;
      shreg     <= shreg_nxt;
      duty_r    <= duty_r_nxt;
      prescaler <= prescaler_nxt;
      pwm_cnt   <= pwm_cnt_nxt;
      blink_ph  <= blink_ph_nxt;
      leds      <= leds_nxt;
      step_tick <= step_tick_nxt;
    end
  end

  always_comb begin
    mode_r_nxt    = mode_r;
    dir_nxt       = dir;
    shreg_nxt     = shreg;
    duty_r_nxt    = duty_r;
    prescaler_nxt = prescaler;
    blink_ph_nxt  = blink_ph;
    step_tick_nxt = 1'b0;
    pwm_cnt_nxt   = pwm_cnt + 1'b1;

    // Output is built from the state before this edge, so leds trails the
    // internal pattern by one cycle.
    vis      = (mode_r == MODE_BLINK && !blink_ph) ? '0 : shreg;
    pwm_on   = (duty_r == '1) || (pwm_cnt < duty_r);
    leds_nxt = vis & {NUM_LEDS{pwm_on}};

    if (load) begin
      // A load always wins over a pending step so the first step lands a
      // full PRESCALE cycles after the load edge.
      mode_r_nxt    = mode_e'(mode);
      shreg_nxt     = pattern;
      duty_r_nxt    = duty;
      prescaler_nxt = '0;
      blink_ph_nxt  = 1'b1;
      dir_nxt       = DIR_LEFT;
    end else if (prescaler == PS_LAST) begin
      prescaler_nxt = '0;
      step_tick_nxt = 1'b1;
      case (mode_r)
        MODE_BLINK: blink_ph_nxt = ~blink_ph;
        MODE_CHASE: shreg_nxt = {shreg[NUM_LEDS-2:0], shreg[NUM_LEDS-1]};
        MODE_BOUNCE: begin
          // Turn around on the step that would push a lit bit off the end,
          // so the end position is shown exactly once.
          if (dir == DIR_LEFT) begin
            if (shreg[NUM_LEDS-1]) begin
              dir_nxt   = DIR_RIGHT;
              shreg_nxt = {1'b0, shreg[NUM_LEDS-1:1]};
            end else begin
              shreg_nxt = {shreg[NUM_LEDS-2:0], 1'b0};
            end
          end else begin
            if (shreg[0]) begin
              dir_nxt   = DIR_LEFT;
              shreg_nxt = {shreg[NUM_LEDS-2:0], 1'b0};
            end else begin
              shreg_nxt = {1'b0, shreg[NUM_LEDS-1:1]};
            end
          end
        end
        default: ;
      endcase
    end else begin
      prescaler_nxt = prescaler + 1'b1;
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
module tb_led_pattern_ctrl;

  localparam int N = 5;
  localparam int P = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [1:0]   mode;
  logic [N-1:0] pattern;
  logic [W-1:0] duty;
  logic [N-1:0] leds;
  logic         step_tick;

  int checks   = 0;
  int failures = 0;

  led_pattern_ctrl #(.NUM_LEDS(N), .PRESCALE(P), .PWM_BITS(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .mode      (mode),
    .pattern   (pattern),
    .duty      (duty),
    .leds      (leds),
    .step_tick (step_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           r;
    bit           l;
    logic [1:0]   m;
    logic [N-1:0] p;
    logic [W-1:0] d;
    int           idle;
    logic [N-1:0] exp_leds;
    bit           exp_tick;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit l, logic [1:0] m, logic [N-1:0] p,
                              logic [W-1:0] d, int idle,
                              logic [N-1:0] el, bit et);
    vec_t v;
    v.r = r; v.l = l; v.m = m; v.p = p; v.d = d;
    v.idle = idle; v.exp_leds = el; v.exp_tick = et;
    return v;
  endfunction

  // One rising edge; returns on the following falling edge, where outputs
  // are sampled and new inputs are driven.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(bit r, bit l, logic [1:0] m, logic [N-1:0] p, logic [W-1:0] d);
    rst = r; load = l; mode = m; pattern = p; duty = d;
  endtask

  task automatic check_leds(string name, logic [N-1:0] exp);
    checks++;
    if (leds !== exp) begin
      failures++;
      $display("FAIL %s leds actual=%b expected=%b t=%0t", name, leds, exp, $time);
    end
  endtask

  task automatic check_tick(string name, logic exp);
    checks++;
    if (step_tick !== exp) begin
      failures++;
      $display("FAIL %s step_tick actual=%b expected=%b t=%0t", name, step_tick, exp, $time);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    // STATIC full brightness
    vecs.push_back(mk(1'b0, 1'b1, 2'd0, 5'b11011, 2'd3, 1, 5'b11011, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 1, 5'b11011, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 0, 5'b11011, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 0, 5'b11011, 1'b0));
    // CHASE: load edge still shows the old pattern (registered lag)
    vecs.push_back(mk(1'b0, 1'b1, 2'd2, 5'b00001, 2'd3, 0, 5'b11011, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 0, 5'b00001, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 2, 5'b00001, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 0, 5'b00010, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 3, 5'b00100, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 3, 5'b01000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 3, 5'b10000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 3, 5'b00001, 1'b0));
    // BOUNCE
    vecs.push_back(mk(1'b0, 1'b1, 2'd3, 5'b00001, 2'd3, 1, 5'b00001, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 3, 5'b00010, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 3, 5'b00100, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 3, 5'b01000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 3, 5'b10000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 3, 5'b01000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 3, 5'b00100, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 3, 5'b00010, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 3, 5'b00001, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 3, 5'b00010, 1'b0));

    // Reset
    drive(1'b1, 1'b0, 2'd0, '0, '0);
    cyc();
    cyc();
    check_leds("reset_leds", 5'b00000);
    check_tick("reset_tick", 1'b0);
    drive(1'b0, 1'b0, 2'd0, '0, '0);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check_leds("post_reset_leds", 5'b00000);
      check_tick("post_reset_tick", (k % 4) == 0);
    end

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].l, vecs[i].m, vecs[i].p, vecs[i].d);
      cyc();
      drive(1'b0, 1'b0, 2'd0, '0, '0);
      repeat (vecs[i].idle) cyc();
      check_leds($sformatf("vec%0d", i), vecs[i].exp_leds);
      check_tick($sformatf("vec%0d", i), vecs[i].exp_tick);
    end

    // BLINK + PWM duty 1: on-phase shows the pattern 1 of 4 cycles
    drive(1'b0, 1'b1, 2'd1, 5'b10101, 2'd1);
    cyc();
    drive(1'b0, 1'b0, 2'd0, '0, '0);
    for (int w = 0; w < 3; w++) begin
      cnt = 0;
      for (int j = 0; j < 4; j++) begin
        cyc();
        check_tick("blink_tick", j == 3);
        if (leds === 5'b10101) cnt++;
        else check_leds("blink_dark", 5'b00000);
      end
      check_int($sformatf("blink_window%0d_on_count", w), cnt, (w % 2 == 0) ? 1 : 0);
    end

    // BLINK duty 0: always dark
    drive(1'b0, 1'b1, 2'd1, 5'b10101, 2'd0);
    cyc();
    drive(1'b0, 1'b0, 2'd0, '0, '0);
    for (int k = 0; k < 12; k++) begin
      cyc();
      check_leds("duty0", 5'b00000);
    end

    // STATIC duty 2: half of the cycles lit
    drive(1'b0, 1'b1, 2'd0, 5'b11111, 2'd2);
    cyc();
    drive(1'b0, 1'b0, 2'd0, '0, '0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (leds === 5'b11111) cnt++;
      else check_leds("duty2_dark", 5'b00000);
    end
    check_int("duty2_on_count", cnt, 4);

    // Load colliding with prescaler at its last count
    drive(1'b0, 1'b1, 2'd0, 5'b00110, 2'd3);
    cyc();
    drive(1'b0, 1'b0, 2'd0, '0, '0);
    repeat (3) cyc();
    check_leds("coll_pre_leds", 5'b00110);
    drive(1'b0, 1'b1, 2'd0, 5'b01100, 2'd3);
    cyc();
    check_tick("coll_load_edge", 1'b0);
    drive(1'b0, 1'b0, 2'd0, '0, '0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check_tick("coll_after", k == 4);
    end
    check_leds("coll_leds", 5'b01100);

    // Reset together with load: load ignored
    drive(1'b1, 1'b1, 2'd2, 5'b11111, 2'd3);
    cyc();
    check_leds("rstload_leds", 5'b00000);
    check_tick("rstload_tick", 1'b0);
    drive(1'b0, 1'b0, 2'd0, '0, '0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check_leds("rstload_after_leds", 5'b00000);
      check_tick("rstload_after_tick", (k % 4) == 0);
    end

    // Reset mid-operation
    drive(1'b0, 1'b1, 2'd2, 5'b00011, 2'd3);
    cyc();
    drive(1'b0, 1'b0, 2'd0, '0, '0);
    repeat (5) cyc();
    check_leds("midrst_running", 5'b00110);
    drive(1'b1, 1'b0, 2'd0, '0, '0);
    cyc();
    check_leds("midrst_leds", 5'b00000);
    check_tick("midrst_tick", 1'b0);
    drive(1'b0, 1'b0, 2'd0, '0, '0);
    cyc();
    check_leds("midrst_after", 5'b00000);

    // Load held high: no steps, prescaler pinned at 0
    drive(1'b0, 1'b1, 2'd2, 5'b00001, 2'd3);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      check_tick("hold_tick", 1'b0);
      if (k > 1) check_leds("hold_leds", 5'b00001);
    end
    drive(1'b0, 1'b0, 2'd0, '0, '0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check_tick("hold_release_tick", k == 4);
      check_leds("hold_release_leds", 5'b00001);
    end
    cyc();
    check_leds("hold_first_step", 5'b00010);

    // All-zero pattern in BOUNCE stays dark through several steps
    drive(1'b0, 1'b1, 2'd3, 5'b00000, 2'd3);
    cyc();
    drive(1'b0, 1'b0, 2'd0, '0, '0);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check_leds("zero_bounce", 5'b00000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
